// File: rtl/seq_shifter.sv
// Sequential 8-bit shifter/rotator: one bit-step per clock, result and carry
// presented together with a single-cycle done pulse.
module seq_shifter (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [2:0] op,
   input  logic [2:0] amt,
   output logic       busy,
   output logic       done,
   output logic [7:0] y,
   output logic       carry
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t     r_state;
   logic [7:0] r_work;
   logic [2:0] r_cnt;
   logic       r_left;
   logic       r_rot;
   logic       r_fill;

   logic       w_valid;
   logic       w_op_left;
   logic       w_op_rot;
   logic       w_op_fill;
   logic       w_out_bit;
   logic       w_in_bit;
   logic [7:0] w_step;

   always_comb begin
      w_valid   = 1'b1;
      w_op_left = 1'b0;
      w_op_rot  = 1'b0;
      w_op_fill = 1'b0;
      case (op)
         3'b001: w_op_left = 1'b1;
         3'b100: w_op_left = 1'b0;
         3'b101: begin w_op_left = 1'b1; w_op_fill = 1'b1; end
         3'b110: w_op_fill = 1'b1;
         3'b010: begin w_op_left = 1'b1; w_op_rot = 1'b1; end
         3'b011: w_op_rot = 1'b1;
         default: w_valid = 1'b0;
      endcase
   end

   // A rotate feeds the outgoing bit back in; a shift feeds the fill constant.
   assign w_out_bit = r_left ? r_work[7] : r_work[0];
   assign w_in_bit  = r_rot ? w_out_bit : r_fill;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_step
         if (gi == 0) begin : g_lsb
            assign w_step[gi] = r_left ? w_in_bit : r_work[gi+1];
         end else if (gi == 7) begin : g_msb
            assign w_step[gi] = r_left ? r_work[gi-1] : w_in_bit;
         end else begin : g_mid
            assign w_step[gi] = r_left ? r_work[gi-1] : r_work[gi+1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_work  <= 8'h00;
         r_cnt   <= 3'd0;
         r_left  <= 1'b0;
         r_rot   <= 1'b0;
         r_fill  <= 1'b0;
         y       <= 8'h00;
         carry   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (w_valid && (amt != 3'd0)) begin
                     r_work  <= a;
                     r_cnt   <= amt;
                     r_left  <= w_op_left;
                     r_rot   <= w_op_rot;
                     r_fill  <= w_op_fill;
                     r_state <= ST_SHIFT;
                  end else begin
                     y       <= a;
                     carry   <= 1'b0;
                     done    <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               r_work <= w_step;
               r_cnt  <= r_cnt - 3'd1;
               // y/carry only move on the final step so partial results stay hidden.
               if (r_cnt == 3'd1) begin
                  y       <= w_step;
                  carry   <= w_out_bit;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized and directed bench for seq_shifter, checked every cycle against
// an arithmetic reference model of occupancy and results.
module tb_seq_shifter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [2:0] op;
   logic [2:0] amt;
   logic       busy;
   logic       done;
   logic [7:0] y;
   logic       carry;

   int n_checks = 0;
   int n_err    = 0;
   bit armed    = 1'b0;

   seq_shifter dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .op    (op),
      .amt   (amt),
      .busy  (busy),
      .done  (done),
      .y     (y),
      .carry (carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_valid(input logic [2:0] o);
      return (o inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110});
   endfunction

   // Returns {carry, y} computed directly from shift arithmetic.
   function automatic logic [8:0] ref_op(input logic [7:0] av, input logic [2:0] o,
                                         input logic [2:0] n);
      int x;
      int k;
      int r;
      int c;
      x = int'(av);
      k = int'(n);
      if (k == 0 || !is_valid(o)) return {1'b0, av};
      r = 0;
      c = 0;
      case (o)
         3'b001: begin r = x << k;                       c = (x >> (8 - k)) & 1; end
         3'b101: begin r = (x << k) | ((1 << k) - 1);    c = (x >> (8 - k)) & 1; end
         3'b100: begin r = x >> k;                       c = (x >> (k - 1)) & 1; end
         3'b110: begin r = (x >> k) | (255 << (8 - k));  c = (x >> (k - 1)) & 1; end
         3'b010: begin r = (x << k) | (x >> (8 - k));    c = r & 1; end
         default: begin r = (x >> k) | (x << (8 - k));   c = (r >> 7) & 1; end
      endcase
      return {c[0], r[7:0]};
   endfunction

   // Model: m_left counts remaining busy cycles; done is the last of them.
   int         m_left = 0;
   logic [7:0] m_y    = 8'h00;
   logic       m_c    = 1'b0;
   logic [8:0] m_pend = 9'h000;

   always @(posedge clk) begin
      if (rst) begin
         m_left <= 0;
         m_y    <= 8'h00;
         m_c    <= 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            m_pend <= ref_op(a, op, amt);
            if (is_valid(op) && amt != 3'd0) begin
               m_left <= int'(amt) + 1;
            end else begin
               m_left <= 1;
               m_y    <= a;
               m_c    <= 1'b0;
            end
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 2) begin
            m_y <= m_pend[7:0];
            m_c <= m_pend[8];
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("busy", int'(busy), int'(m_left != 0));
         check("done", int'(done), int'(m_left == 1));
         check("y", int'(y), int'(m_y));
         check("carry", int'(carry), int'(m_c));
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("idle_wait", int'(busy), 0);
   endtask

   // Issue one request from an idle cycle; mode 1 scrambles inputs while busy.
   task automatic do_req(input logic [7:0] av, input logic [2:0] o, input logic [2:0] n,
                         input int mode, output int lat, output logic [7:0] ry,
                         output logic rc);
      wait_idle();
      a     = av;
      op    = o;
      amt   = n;
      start = 1'b1;
      @(posedge clk);
      lat = 0;
      ry  = 8'hxx;
      rc  = 1'bx;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (done) begin
            ry    = y;
            rc    = carry;
            start = 1'b0;
            break;
         end
         start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (mode == 1) begin
            a   = 8'($urandom);
            op  = 3'($urandom);
            amt = 3'($urandom);
         end
      end
      start = 1'b0;
   endtask

   task automatic directed(input logic [7:0] av, input logic [2:0] o, input logic [2:0] n,
                           input logic [7:0] ey, input logic ec, input int elat);
      int         lat;
      logic [7:0] ry;
      logic       rc;
      do_req(av, o, n, 0, lat, ry, rc);
      check("dir_latency", lat, elat);
      check("dir_y", int'(ry), int'(ey));
      check("dir_carry", int'(rc), int'(ec));
      $display("dir a=%02h op=%03b amt=%0d -> y=%02h carry=%0d lat=%0d", av, o, n, ry, rc, lat);
   endtask

   initial begin
      int         lat;
      int         nb;
      int         nd;
      logic [7:0] ry;
      logic       rc;
      logic [8:0] e;

      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      op    = 3'b000;
      amt   = 3'd0;
      @(negedge clk);
      @(negedge clk);
      armed = 1'b1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_y", int'(y), 0);
      check("rst_carry", int'(carry), 0);
      rst = 1'b0;

      directed(8'h99, 3'b001, 3'd1, 8'h32, 1'b1, 2);
      directed(8'h99, 3'b110, 3'd1, 8'hCC, 1'b1, 2);
      directed(8'h99, 3'b010, 3'd3, 8'hCC, 1'b0, 4);
      directed(8'h99, 3'b011, 3'd2, 8'h66, 1'b0, 3);
      directed(8'h99, 3'b101, 3'd3, 8'hCF, 1'b0, 4);
      directed(8'h99, 3'b000, 3'd5, 8'h99, 1'b0, 1);
      directed(8'h99, 3'b001, 3'd0, 8'h99, 1'b0, 1);
      directed(8'h99, 3'b111, 3'd7, 8'h99, 1'b0, 1);
      directed(8'h81, 3'b001, 3'd7, 8'h80, 1'b0, 8);
      directed(8'h81, 3'b100, 3'd7, 8'h01, 1'b0, 8);

      // start held high through a 7-step op; the next request enters from IDLE
      wait_idle();
      a     = 8'h99;
      op    = 3'b001;
      amt   = 3'd7;
      start = 1'b1;
      @(posedge clk);
      nb = 0;
      nd = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) begin
            a   = 8'h5A;
            op  = 3'b011;
            amt = 3'd2;
         end
         nb += int'(busy);
         nd += int'(done);
      end
      check("hold_busy_cycles", nb, 8);
      check("hold_done_pulses", nd, 1);
      @(negedge clk);
      check("hold_second_accept", int'(busy), 1);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("hold_second_latency", lat, 3);
      check("hold_second_y", int'(y), 8'h96);
      check("hold_second_carry", int'(carry), 1);
      $display("hold busy=%0d dones=%0d second y=%02h carry=%0d", nb, nd, y, carry);

      // reset during the 3rd SHIFT cycle of an amt=5 op
      wait_idle();
      a     = 8'h99;
      op    = 3'b001;
      amt   = 3'd5;
      start = 1'b1;
      @(posedge clk);
      nd = 0;
      @(negedge clk);
      start = 1'b0;
      nd += int'(done);
      @(negedge clk);
      nd += int'(done);
      @(negedge clk);
      nd += int'(done);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_no_done", nd + int'(done), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_y", int'(y), 0);
      check("abort_carry", int'(carry), 0);
      $display("abort busy=%0d done=%0d y=%02h carry=%0d", busy, done, y, carry);
      directed(8'h99, 3'b100, 3'd2, 8'h26, 1'b0, 3);

      // exhaustive operand/op/amount sweep with scrambled inputs while busy
      for (int av = 0; av < 256; av++) begin
         for (int o = 1; o <= 6; o++) begin
            for (int n = 0; n < 8; n++) begin
               e = ref_op(8'(av), 3'(o), 3'(n));
               do_req(8'(av), 3'(o), 3'(n), 1, lat, ry, rc);
               check("sweep_latency", lat, n + 1);
               check("sweep_y", int'(ry), int'(e[7:0]));
               check("sweep_carry", int'(rc), int'(e[8]));
            end
         end
         $display("sweep a=%02h last y=%02h carry=%0d", 8'(av), ry, rc);
      end

      for (int i = 0; i < 32; i++) begin
         logic [7:0] ra;
         logic [2:0] ro;
         logic [2:0] rn;
         ra = 8'($urandom);
         ro = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
         rn = 3'($urandom);
         do_req(ra, ro, rn, 1, lat, ry, rc);
         check("noop_latency", lat, 1);
         check("noop_y", int'(ry), int'(ra));
         check("noop_carry", int'(rc), 0);
         $display("noop a=%02h op=%03b amt=%0d -> y=%02h carry=%0d", ra, ro, rn, ry, rc);
      end

      wait_idle();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
